video_ram_mc: RTL and testbench
===============================

Name: video_ram_mc

Overview:
- Next-generation video RAM for the video chip: parametrised width/depth true dual-port array.
- Port A is shared by the CPU and an internal fill/clear engine. Port B is time-shared round-robin among NCH video fetch channels (e.g. bitmap, sprite, text).
- Adds read-valid strobes, selectable read-during-write mode and a hardware block-fill engine that the fixed 32 KiB single-channel RAM lacks.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 15, address width; DEPTH = 2**ADDR_W words.
- NCH, 2, number of video fetch channels (1..8).
- RDW_MODE, 0, CPU read-during-write at the same address: 0 = old data, 1 = new data.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_add  in  ADDR_W  CPU word address.
- cpu_in_data  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_re  in  1  CPU read strobe.
- cpu_out_data  out  DATA_W  CPU read data, registered.
- cpu_valid  out  1  cpu_out_data updated this cycle.
- cpu_stall  out  1  port A owned by fill engine; CPU strobes ignored.
- vid_req  in  NCH  per-channel fetch request.
- vid_add  in  NCH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W].
- vid_gnt  out  NCH  one-hot grant, combinational, same cycle as request.
- vid_data  out  DATA_W  fetched word, registered.
- vid_valid  out  NCH  one-hot; vid_data belongs to this channel.
- fill_start  in  1  start fill (pulse).
- fill_base  in  ADDR_W  first fill address.
- fill_len  in  ADDR_W+1  words to fill (0..DEPTH).
- fill_value  in  DATA_W  fill word.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: cpu_out_data=0, cpu_valid=0, vid_data=0, vid_valid=0, fill_busy=0, fill_done=0, round-robin pointer=0, FSM=IDLE. RAM contents are not reset.
- cpu_stall = fill_busy (combinational).
- CPU reads:
  - Accepted when cpu_re=1 and cpu_stall=0.
  - cpu_out_data and cpu_valid appear one cycle later; cpu_valid is a one-cycle pulse.
  - cpu_out_data holds its value until the next accepted read.
- CPU writes:
  - Accepted when cpu_we=1 and cpu_stall=0; written at the clock edge.
  - If cpu_re is also 1, a read of the same address returns old data (RDW_MODE=0) or cpu_in_data (RDW_MODE=1), with cpu_valid next cycle.
- Strobes issued while stalled are dropped; the CPU must retry after cpu_stall falls.
- Video arbiter:
  - Each cycle, grants the first requesting channel at or after the pointer, searching upward and wrapping modulo NCH.
  - Pointer becomes granted index + 1 (mod NCH); it is unchanged when nothing is granted.
  - Granted channel's address is read on port B; vid_data and vid_valid[ch] follow one cycle later.
  - vid_valid=0 in any cycle following no grant; vid_data then holds its last value.
  - Losing channels must hold their request.
- Cross-port collision: port B reading an address port A writes in the same cycle returns old data.
- Fill FSM, states IDLE, FILL, DONE:
  - IDLE: fill_start=1 latches base, len and value into ptr, cnt and val. cnt=0 -> DONE; otherwise -> FILL with fill_busy=1 from the next cycle.
  - FILL: writes val at ptr each cycle; ptr increments with wrap modulo DEPTH; cnt decrements. Last write (cnt=1) -> DONE.
  - DONE: fill_done=1 and fill_busy=0 for one cycle -> IDLE.
  - fill_start outside IDLE is ignored.
  - fill_len=DEPTH fills the entire array in DEPTH cycles.
  - Video fetches continue unaffected during FILL.
- rst asserted mid-fill aborts immediately to IDLE with no further writes. Already-written words remain.

Decomposition:
- Shared package video_pkg holds:
  - default DATA_W/ADDR_W constants;
  - fill FSM state enum (IDLE, FILL, DONE);
  - RDW mode constants RDW_OLD=0, RDW_NEW=1.
- One sub-module, vram_rr_arb: parametrised NCH round-robin arbiter providing grant, pointer and encoded index.
- Memory array and fill FSM stay in the top module.

Test Plan:
- CPU write 0xA5 to 0x0010, then read 0x0010 -> cpu_valid pulse next cycle, cpu_out_data=0xA5.
- RDW_MODE=0: mem[0x20]=0x11; we+re at 0x20 with data 0x22 -> cpu_out_data=0x11. RDW_MODE=1 build, same stimulus -> 0x22.
- NCH=2, both vid_req held 4 cycles at 0x100/0x200 (mem 0x01/0x02) -> grants alternate ch0,ch1,ch0,ch1; vid_valid and vid_data track grants one cycle later.
- Fill base 0x7FFE, len 4, value 0x3C -> 4 busy cycles; addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001 read back 0x3C; 0x0002 unchanged; fill_done single pulse.
- During fill, cpu_we to 0x0050 -> cpu_stall=1 and write dropped. fill_len=0 -> fill_done next cycle, no writes.
- rst after 2 fill writes -> fill_busy=0 next cycle; only the first 2 words are modified; outputs return to reset values.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and fill FSM encoding for the video RAM controller.
package video_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 15;

  typedef logic [1:0] fill_state_t;

  localparam fill_state_t ST_IDLE = 2'd0;
  localparam fill_state_t ST_FILL = 2'd1;
  localparam fill_state_t ST_DONE = 2'd2;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/vram_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner.
module vram_rr_arb #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   i_req,
  output logic [NCH-1:0]   o_gnt_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_nxt_ptr;
  logic [NCH-1:0]   w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Wrapping search starting at the pointer
  always_comb begin
    int unsigned c;
    logic [IDX_W-1:0] w_c;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    c       = 0;
    w_c     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c   = (32'(r_ptr) + k) % NCH;
      w_c = IDX_W'(c);
      if (!w_found && i_req[w_c]) begin
        w_found    = 1'b1;
        w_gnt[w_c] = 1'b1;
        w_idx      = w_c;
      end
    end
  end

  always_comb begin
    w_nxt_ptr = r_ptr;
    if (w_found) begin
      w_nxt_ptr = IDX_W'((32'(w_idx) + 32'd1) % NCH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_nxt_ptr;
    end
  end

  assign o_gnt_c = w_gnt;
  assign o_idx_c = w_idx;
  assign o_any_c = w_found;

endmodule

// File: rtl/video_ram_mc.sv
// Dual-port video RAM: port A shared by CPU and block-fill engine,
// port B round-robin among NCH video fetch channels.
module video_ram_mc
  import video_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NCH      = 2,
  parameter int          RDW_MODE = RDW_OLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     cpu_add,
  input  logic [DATA_W-1:0]     cpu_in_data,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [DATA_W-1:0]     cpu_out_data,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  input  logic [NCH-1:0]        vid_req,
  input  logic [NCH*ADDR_W-1:0] vid_add,
  output logic [NCH-1:0]        vid_gnt,
  output logic [DATA_W-1:0]     vid_data,
  output logic [NCH-1:0]        vid_valid,
  input  logic                  fill_start,
  input  logic [ADDR_W-1:0]     fill_base,
  input  logic [ADDR_W:0]       fill_len,
  input  logic [DATA_W-1:0]     fill_value,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  fill_state_t       r_state, w_nxt_state;
  logic [ADDR_W-1:0] r_ptr, w_nxt_ptr;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [DATA_W-1:0] r_val, w_nxt_val;
  logic              r_fill_busy;
  logic              r_fill_done;

  logic [DATA_W-1:0] r_cpu_out;
  logic              r_cpu_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic [NCH-1:0]    r_vid_valid;

  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic              w_fill_wr;
  logic              w_a_we;
  logic [ADDR_W-1:0] w_a_addr;
  logic [DATA_W-1:0] w_a_wdata;
  logic [DATA_W-1:0] w_cpu_rdata;

  logic [NCH-1:0]    w_vid_gnt;
  logic [IDX_W-1:0]  w_vid_idx;
  logic              w_vid_any;
  logic [ADDR_W-1:0] w_vid_addr;

  // Fill FSM next-state logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_val   = r_val;
    case (r_state)
      ST_IDLE: begin
        if (fill_start) begin
          w_nxt_ptr   = fill_base;
          w_nxt_cnt   = fill_len;
          w_nxt_val   = fill_value;
          w_nxt_state = (fill_len == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        w_nxt_ptr = r_ptr + ADDR_W'(1);
        w_nxt_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_nxt_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_val       <= '0;
      r_fill_busy <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_ptr       <= w_nxt_ptr;
      r_cnt       <= w_nxt_cnt;
      r_val       <= w_nxt_val;
      r_fill_busy <= (w_nxt_state == ST_FILL);
      r_fill_done <= (w_nxt_state == ST_DONE);
    end
  end

  // Port A ownership: the fill engine locks out the CPU while running
  assign w_fill_wr = (r_state == ST_FILL);
  assign w_cpu_wr  = cpu_we & ~r_fill_busy;
  assign w_cpu_rd  = cpu_re & ~r_fill_busy;
  assign w_a_we    = ~rst & (w_fill_wr | w_cpu_wr);
  assign w_a_addr  = w_fill_wr ? r_ptr : cpu_add;
  assign w_a_wdata = w_fill_wr ? r_val : cpu_in_data;

  always_ff @(posedge clk) begin
    if (w_a_we) begin
      r_mem[w_a_addr] <= w_a_wdata;
    end
  end

  assign w_cpu_rdata = ((RDW_MODE == RDW_NEW) && w_cpu_wr) ? cpu_in_data
                                                           : r_mem[cpu_add];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_out   <= '0;
      r_cpu_valid <= 1'b0;
    end else begin
      r_cpu_valid <= w_cpu_rd;
      if (w_cpu_rd) begin
        r_cpu_out <= w_cpu_rdata;
      end
    end
  end

  vram_rr_arb #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (vid_req),
    .o_gnt_c (w_vid_gnt),
    .o_idx_c (w_vid_idx),
    .o_any_c (w_vid_any)
  );

  assign w_vid_addr = vid_add[32'(w_vid_idx)*ADDR_W +: ADDR_W];

  // Port B read; a same-cycle port A write is seen as old data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vid_data  <= '0;
      r_vid_valid <= '0;
    end else begin
      r_vid_valid <= w_vid_gnt;
      if (w_vid_any) begin
        r_vid_data <= r_mem[w_vid_addr];
      end
    end
  end

  assign cpu_out_data = r_cpu_out;
  assign cpu_valid    = r_cpu_valid;
  assign cpu_stall    = r_fill_busy;
  assign vid_gnt      = w_vid_gnt;
  assign vid_data     = r_vid_data;
  assign vid_valid    = r_vid_valid;
  assign fill_busy    = r_fill_busy;
  assign fill_done    = r_fill_done;

endmodule

// File: tb/tb_video_ram_mc.sv
// Directed bench for video_ram_mc: CPU access, RDW modes, video arbitration, fill engine.
module tb_video_ram_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] cpu_add;
  logic [7:0]  cpu_in_data;
  logic        cpu_we, cpu_re;
  logic [7:0]  cpu_out_data, n_cpu_out_data;
  logic        cpu_valid, n_cpu_valid;
  logic        cpu_stall, n_cpu_stall;
  logic [1:0]  vid_req;
  logic [29:0] vid_add;
  logic [1:0]  vid_gnt, n_vid_gnt;
  logic [7:0]  vid_data, n_vid_data;
  logic [1:0]  vid_valid, n_vid_valid;
  logic        fill_start;
  logic [14:0] fill_base;
  logic [15:0] fill_len;
  logic [7:0]  fill_value;
  logic        fill_busy, n_fill_busy;
  logic        fill_done, n_fill_done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  video_ram_mc #(.DATA_W(8), .ADDR_W(15), .NCH(2), .RDW_MODE(0)) dut (
    .clk(clk), .rst(rst), .cpu_add(cpu_add), .cpu_in_data(cpu_in_data),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_out_data(cpu_out_data),
    .cpu_valid(cpu_valid), .cpu_stall(cpu_stall), .vid_req(vid_req),
    .vid_add(vid_add), .vid_gnt(vid_gnt), .vid_data(vid_data),
    .vid_valid(vid_valid), .fill_start(fill_start), .fill_base(fill_base),
    .fill_len(fill_len), .fill_value(fill_value), .fill_busy(fill_busy),
    .fill_done(fill_done)
  );

  video_ram_mc #(.DATA_W(8), .ADDR_W(15), .NCH(2), .RDW_MODE(1)) dut_new (
    .clk(clk), .rst(rst), .cpu_add(cpu_add), .cpu_in_data(cpu_in_data),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_out_data(n_cpu_out_data),
    .cpu_valid(n_cpu_valid), .cpu_stall(n_cpu_stall), .vid_req(vid_req),
    .vid_add(vid_add), .vid_gnt(n_vid_gnt), .vid_data(n_vid_data),
    .vid_valid(n_vid_valid), .fill_start(fill_start), .fill_base(fill_base),
    .fill_len(fill_len), .fill_value(fill_value), .fill_busy(n_fill_busy),
    .fill_done(n_fill_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    cpu_add = a; cpu_in_data = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [14:0] a);
    cpu_add = a; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    chk_cnt++;
    if ({cpu_out_data, cpu_valid, vid_data, vid_valid} !== 19'd0)
      $display("FAIL reset_outputs: got %h expected 0", {cpu_out_data, cpu_valid, vid_data, vid_valid});
    else pass_cnt++;
    chk_cnt++;
    if ({fill_busy, fill_done, cpu_stall} !== 3'b000)
      $display("FAIL reset_fill: got %b expected 000", {fill_busy, fill_done, cpu_stall});
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_rw();
    cpu_write(15'h0010, 8'hA5);
    cpu_read(15'h0010);
    chk_cnt++;
    if (cpu_valid !== 1'b1) $display("FAIL cpu_valid_pulse: got %b expected 1", cpu_valid);
    else pass_cnt++;
    chk_cnt++;
    if (cpu_out_data !== 8'hA5) $display("FAIL cpu_read_data: got %h expected a5", cpu_out_data);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({cpu_valid, cpu_out_data} !== {1'b0, 8'hA5})
      $display("FAIL cpu_read_hold: got %b/%h expected 0/a5", cpu_valid, cpu_out_data);
    else pass_cnt++;
  endtask

  task automatic test_rdw();
    cpu_write(15'h0020, 8'h11);
    cpu_add = 15'h0020; cpu_in_data = 8'h22; cpu_we = 1'b1; cpu_re = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
    chk_cnt++;
    if ({cpu_valid, cpu_out_data} !== {1'b1, 8'h11})
      $display("FAIL rdw_old: got %b/%h expected 1/11", cpu_valid, cpu_out_data);
    else pass_cnt++;
    chk_cnt++;
    if ({n_cpu_valid, n_cpu_out_data} !== {1'b1, 8'h22})
      $display("FAIL rdw_new: got %b/%h expected 1/22", n_cpu_valid, n_cpu_out_data);
    else pass_cnt++;
    cpu_read(15'h0020);
    chk_cnt++;
    if (cpu_out_data !== 8'h22) $display("FAIL rdw_written: got %h expected 22", cpu_out_data);
    else pass_cnt++;
  endtask

  task automatic test_video();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    cpu_write(15'h0100, 8'h01);
    cpu_write(15'h0200, 8'h02);
    vid_add = {15'h0200, 15'h0100};
    vid_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 8'h01 : 8'h02;
      #1;
      chk_cnt++;
      if (vid_gnt !== exp_g) $display("FAIL vid_gnt_%0d: got %b expected %b", i, vid_gnt, exp_g);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({vid_valid, vid_data} !== {exp_g, exp_d})
        $display("FAIL vid_fetch_%0d: got %b/%h expected %b/%h", i, vid_valid, vid_data, exp_g, exp_d);
      else pass_cnt++;
    end
    // Pointer is back at 0: a lone ch1 request must still win
    vid_req = 2'b10;
    #1;
    chk_cnt++;
    if (vid_gnt !== 2'b10) $display("FAIL vid_lone_ch1: got %b expected 10", vid_gnt);
    else pass_cnt++;
    vid_req = 2'b00;
    #1;
    chk_cnt++;
    if (vid_gnt !== 2'b00) $display("FAIL vid_no_req: got %b expected 00", vid_gnt);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({vid_valid, vid_data} !== {2'b00, 8'h02})
      $display("FAIL vid_idle_hold: got %b/%h expected 00/02", vid_valid, vid_data);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [14:0] ra [7];
    logic [7:0]  re [7];
    int busy_cnt, done_cnt, done_at;
    ra = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0002, 15'h7FFD, 15'h0050};
    re = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h77, 8'h55, 8'h44};
    cpu_write(15'h0002, 8'h77);
    cpu_write(15'h7FFD, 8'h55);
    cpu_write(15'h0050, 8'h44);
    fill_base = 15'h7FFE; fill_len = 16'd4; fill_value = 8'h3C; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      cpu_add = 15'h0050; cpu_in_data = 8'hEE; cpu_we = (i < 4);
      // Second start while filling must be ignored
      if (i == 1) begin
        fill_base = 15'h0002; fill_len = 16'd1; fill_value = 8'h99; fill_start = 1'b1;
      end else begin
        fill_start = 1'b0;
      end
      #1;
      if (i == 0) begin
        chk_cnt++;
        if (cpu_stall !== 1'b1) $display("FAIL fill_stall: got %b expected 1", cpu_stall);
        else pass_cnt++;
      end
      if (fill_busy === 1'b1) busy_cnt++;
      if (fill_done === 1'b1) begin done_cnt++; done_at = i; end
      tick();
    end
    cpu_we = 1'b0;
    chk_cnt++;
    if (busy_cnt != 4) $display("FAIL fill_busy_cycles: got %0d expected 4", busy_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt != 1 || done_at != 4)
      $display("FAIL fill_done_pulse: got %0d pulses at %0d expected 1 at 4", done_cnt, done_at);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      cpu_read(ra[i]);
      chk_cnt++;
      if (cpu_out_data !== re[i])
        $display("FAIL fill_readback_%h: got %h expected %h", ra[i], cpu_out_data, re[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill_zero();
    cpu_write(15'h0300, 8'h12);
    fill_base = 15'h0300; fill_len = 16'd0; fill_value = 8'h5A; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk_cnt++;
    if ({fill_done, fill_busy} !== 2'b10)
      $display("FAIL fill_zero_done: got %b expected 10", {fill_done, fill_busy});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (fill_done !== 1'b0) $display("FAIL fill_zero_pulse: got %b expected 0", fill_done);
    else pass_cnt++;
    cpu_read(15'h0300);
    chk_cnt++;
    if (cpu_out_data !== 8'h12) $display("FAIL fill_zero_nowrite: got %h expected 12", cpu_out_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] exp [4];
    exp = '{8'hC3, 8'hC3, 8'h12, 8'h13};
    for (int i = 0; i < 4; i++) cpu_write(15'h0400 + 15'(i), 8'h10 + 8'(i));
    vid_add = {15'h0200, 15'h0200};
    vid_req = 2'b01;
    tick();
    vid_req = 2'b00;
    fill_base = 15'h0400; fill_len = 16'd4; fill_value = 8'hC3; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_cnt++;
    if ({fill_busy, fill_done, cpu_stall} !== 3'b000)
      $display("FAIL rst_fill_abort: got %b expected 000", {fill_busy, fill_done, cpu_stall});
    else pass_cnt++;
    chk_cnt++;
    if ({cpu_out_data, cpu_valid, vid_data, vid_valid} !== 19'd0)
      $display("FAIL rst_outputs: got %h expected 0", {cpu_out_data, cpu_valid, vid_data, vid_valid});
    else pass_cnt++;
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({fill_busy, fill_done} !== 2'b00)
      $display("FAIL rst_fsm_idle: got %b expected 00", {fill_busy, fill_done});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cpu_read(15'h0400 + 15'(i));
      chk_cnt++;
      if (cpu_out_data !== exp[i])
        $display("FAIL rst_fill_word_%0d: got %h expected %h", i, cpu_out_data, exp[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; cpu_add = '0; cpu_in_data = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    vid_req = '0; vid_add = '0; fill_start = 1'b0; fill_base = '0;
    fill_len = '0; fill_value = '0;
    test_reset();
    test_cpu_rw();
    test_rdw();
    test_video();
    test_fill();
    test_fill_zero();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
